mux_arbiter: RTL and testbench
==============================

Name: mux_arbiter

Overview:
- Round-robin arbiter and sequencer for the shared 2:1 select datapath. It decides which of two valid/ready requesters (A, B) owns the shared output path.
- Drives the mux select (0 = A, 1 = B, same polarity as the existing mux). Registers the selected beat into a one-deep output stage.
- Grants are held for bursts of up to MAX_BURST beats, then re-arbitrated, so neither requester is starved.

Parameters:
- WIDTH, 8, data width of each requester and the output.
- MAX_BURST, 4, max beats accepted per grant before forced re-arbitration. Legal range 1..255.

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  synchronous, active-high reset
- a_valid  input  1  requester A has a beat
- a_data  input  WIDTH  requester A data
- a_ready  output  1  A beat accepted this cycle when a_valid & a_ready
- b_valid  input  1  requester B has a beat
- b_data  input  WIDTH  requester B data
- b_ready  output  1  B beat accepted this cycle when b_valid & b_ready
- o_valid  output  1  output beat present (registered)
- o_data  output  WIDTH  output data (registered)
- o_ready  input  1  downstream accepts the beat when o_valid & o_ready
- sel  output  1  mux select: 1 in GNT_B, 0 otherwise (combinational from state register)

Interface:
- One clock, clk. Reset rst is synchronous and active-high. No async paths.
- Interface is valid/ready. A source must hold valid and data stable until accepted.

Behaviour:
- Reset (rst=1 sampled at clk edge):
  - state=IDLE, cnt=0, last=B (so A wins the first tie).
  - o_valid=0, o_data=0; a_ready=b_ready=0; sel=0.
  - Reset mid-burst discards any held output beat; no beat is emitted.
- Output stage: space = !o_valid | o_ready.
- States: IDLE, GNT_A, GNT_B. Readies:
  - a_ready = (state==GNT_A) & space.
  - b_ready = (state==GNT_B) & space.
  - Both readies are 0 in IDLE and never 1 together.
- IDLE transitions:
  - Only a_valid -> GNT_A.
  - Only b_valid -> GNT_B.
  - Both valid -> grant the requester that is not `last`.
  - Neither valid -> stay IDLE.
  - Arbitration costs 1 cycle: ready first asserts the cycle after entering GNT_x.
  - On entering GNT_x: cnt=0, last=x.
- In GNT_x, on each accepted beat:
  - o_data <= x_data, o_valid <= 1.
  - cnt increments, width = clog2(MAX_BURST+1).
- o_valid handling:
  - Clears when o_ready & o_valid and no new beat is accepted that cycle.
  - Simultaneous accept-in and drain-out keeps o_valid=1 with the new data. This gives full throughput: 1 beat/cycle.
- Release of GNT_x happens when either:
  - (accept & cnt==MAX_BURST-1), or
  - !x_valid (requester withdrew, no accept).
- On release:
  - If other requester is valid -> GNT_other.
  - Else if x_valid -> re-enter GNT_x (cnt=0).
  - Else -> IDLE.
  - Release-to-switch is a direct 1-cycle transition with no IDLE bubble beyond that cycle's state change.
- Boundaries:
  - MAX_BURST=1 -> alternates every beat when both are valid.
  - o_ready held 0 -> ready stays 0, no counting, grant holds indefinitely. This does not count as release unless x_valid drops.
  - Latency: accepted input -> o_valid next cycle.
- Invariants:
  - Data order within one requester is preserved.
  - No beat is duplicated or dropped.

Optional Feature:
- Macro: MUX_ARB_FIXED_PRIO_EN.
- Defined: A has fixed priority.
  - IDLE with both valid -> GNT_A.
  - On release of GNT_A with a_valid still high -> re-grant A even if b_valid.
  - B is served only when A is idle. Starvation of B is accepted by design.
  - `last` is unused.
- Undefined: round-robin as above.

Test Plan:
- Reset: assert rst for 2 cycles with a_valid=b_valid=1 -> o_valid=0, a_ready=b_ready=0, sel=0. After release, GNT_A is entered first and a_ready=1 on cycle 2 after deassert.
- Single requester: A streams 0x10..0x17, o_ready=1 -> o_data 0x10..0x17 in order, 1/cycle, one 1-cycle re-arbitration gap after every 4th beat, sel=0 throughout.
- Contention: A sends 0xA0.., B sends 0xB0.., both continuously valid, o_ready=1 -> output A0-A3, B0-B3, A4-A7; sel toggles per burst.
- Backpressure: mid-burst, o_ready=0 for 5 cycles -> o_data held stable, a_ready=0, cnt frozen. Burst resumes and finishes at exactly 4 total beats.
- Early withdraw: A drops a_valid after 2 beats while b_valid=1 -> next state GNT_B, B's 4 beats follow, no extra A beat emitted.
- With MUX_ARB_FIXED_PRIO_EN, both continuously valid -> only A beats appear. After A goes idle, B is granted within 2 cycles.

Source files
------------

// File: rtl/mux_arbiter_if.sv
// Valid/ready bundle between two requesters, the arbiter, and the downstream sink.
// The arbiter takes the slave view; whoever drives requests and sinks beats takes master.
interface mux_arbiter_if #(
    parameter int WIDTH = 8
);
    logic             a_valid;
    logic [WIDTH-1:0] a_data;
    logic             a_ready;
    logic             b_valid;
    logic [WIDTH-1:0] b_data;
    logic             b_ready;
    logic             o_valid;
    logic [WIDTH-1:0] o_data;
    logic             o_ready;
    logic             sel;

    modport master (
        output a_valid, a_data, b_valid, b_data, o_ready,
        input  a_ready, b_ready, o_valid, o_data, sel
    );

    modport slave (
        input  a_valid, a_data, b_valid, b_data, o_ready,
        output a_ready, b_ready, o_valid, o_data, sel
    );
endinterface

// File: rtl/mux_arbiter.sv
// Round-robin burst arbiter for the shared 2:1 mux with a one-deep registered output stage.
// Define MUX_ARB_FIXED_PRIO_EN to give requester A fixed priority instead of round-robin.
module mux_arbiter #(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic         clk,
    input  logic         rst,
    mux_arbiter_if.slave bus
);
    localparam int            CW        = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BURST - 1);
`ifdef MUX_ARB_FIXED_PRIO_EN
    localparam bit FIXED_PRIO = 1'b1;
`else
    localparam bit FIXED_PRIO = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, GNT_A, GNT_B} state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             rearb_q, rearb_d;   // grant just re-entered: hold ready off for one cycle
    logic             last_q, last_d;     // 1 = B was the most recent grant
    logic             o_valid_q, o_valid_d;
    logic [WIDTH-1:0] o_data_q, o_data_d;

    logic space, accept, cur_valid, other_valid, release_g;

    assign space       = !o_valid_q || bus.o_ready;
    assign bus.a_ready = (state_q == GNT_A) && !rearb_q && space;
    assign bus.b_ready = (state_q == GNT_B) && !rearb_q && space;
    assign bus.sel     = (state_q == GNT_B);
    assign bus.o_valid = o_valid_q;
    assign bus.o_data  = o_data_q;
    assign accept      = (bus.a_valid && bus.a_ready) || (bus.b_valid && bus.b_ready);

    always_comb begin
        // NOTE: every variable written here gets a default first, so no path can infer a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        rearb_d     = 1'b0;
        last_d      = last_q;
        o_valid_d   = o_valid_q;
        o_data_d    = o_data_q;
        release_g   = 1'b0;
        cur_valid   = (state_q == GNT_B) ? bus.b_valid : bus.a_valid;
        other_valid = (state_q == GNT_B) ? bus.a_valid : bus.b_valid;

        if (accept) begin
            o_valid_d = 1'b1;
            o_data_d  = (state_q == GNT_B) ? bus.b_data : bus.a_data;
        end else if (bus.o_ready) begin
            o_valid_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (bus.a_valid && (!bus.b_valid || FIXED_PRIO || last_q))
                    state_d = GNT_A;
                else if (bus.b_valid)
                    state_d = GNT_B;
            end
            GNT_A, GNT_B: begin
                if (accept)
                    cnt_d = cnt_q + 1'b1;
                release_g = (accept && cnt_q == LAST_BEAT) || !cur_valid;
                if (release_g) begin
                    if (other_valid && !(FIXED_PRIO && state_q == GNT_A && cur_valid))
                        state_d = (state_q == GNT_A) ? GNT_B : GNT_A;
                    else if (cur_valid)
                        rearb_d = 1'b1;
                    else
                        state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Any fresh grant (new owner or re-entry) restarts the burst count.
        if (state_d != IDLE && (state_d != state_q || rearb_d)) begin
            cnt_d  = '0;
            last_d = (state_d == GNT_B);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rearb_q   <= 1'b0;
            last_q    <= 1'b1;
            o_valid_q <= 1'b0;
            o_data_q  <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values computed above.
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rearb_q   <= rearb_d;
            last_q    <= last_d;
            o_valid_q <= o_valid_d;
            o_data_q  <= o_data_d;
        end
    end
endmodule

// File: tb/tb_mux_arbiter.sv
// Self-checking bench for mux_arbiter: cycle table, directed burst/withdraw/reset sequences,
// and a randomized run against a scoreboard of accepted beats and burst-fairness bounds.
module tb_mux_arbiter;
    localparam int WIDTH     = 8;
    localparam int MAX_BURST = 4;
    localparam int NV        = 26;
`ifdef MUX_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    typedef struct {
        logic       av;
        logic [7:0] ad;
        logic       bv;
        logic [7:0] bd;
        logic       ordy;
        logic       ea;
        logic       eb;
        logic       es;
        logic       eov;
        logic [7:0] eod;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mux_arbiter_if #(.WIDTH(WIDTH)) bus ();

    mux_arbiter #(.WIDTH(WIDTH), .MAX_BURST(MAX_BURST)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference state: sources, scoreboard of accepted-but-not-drained beats, output log.
    logic [7:0] a_src_q[$], b_src_q[$], exp_q[$], log_q[$];
    bit         auto_en, rand_mode, a_en, b_en, a_up, b_up;
    bit         mon_ok, acc_prev, ov_prev, or_prev;
    logic [7:0] acc_d_prev, od_prev;
    int         a_acc_n, b_acc_n, a_while_b, b_while_a;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t v(input logic av, input logic [7:0] ad, input logic bv,
                               input logic [7:0] bd, input logic ordy, input logic ea,
                               input logic eb, input logic es, input logic eov,
                               input logic [7:0] eod);
        vec_t r;
        r.av = av; r.ad = ad; r.bv = bv; r.bd = bd; r.ordy = ordy;
        r.ea = ea; r.eb = eb; r.es = es; r.eov = eov; r.eod = eod;
        return r;
    endfunction

    // Sources hold valid/data once raised until the beat is taken.
    task automatic drive_auto();
        if (!a_up) a_up = a_en && a_src_q.size() > 0 && (!rand_mode || $urandom_range(0, 3) != 0);
        if (!b_up) b_up = b_en && b_src_q.size() > 0 && (!rand_mode || $urandom_range(0, 3) != 0);
        bus.a_valid = a_up;
        bus.b_valid = b_up;
        bus.a_data  = 8'h00;
        bus.b_data  = 8'h00;
        if (a_up) bus.a_data = a_src_q[0];
        if (b_up) bus.b_data = b_src_q[0];
        bus.o_ready = rand_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
    endtask

    // Called once per cycle after inputs settle: checks the output stage against last
    // cycle's handshakes, then records the handshakes that the coming edge will take.
    task automatic monitor();
        logic a_acc, b_acc;
        if (rst) begin
            exp_q.delete();
            mon_ok    = 1'b0;
            a_while_b = 0;
            b_while_a = 0;
            return;
        end
        if (mon_ok) begin
            if (acc_prev) begin
                check("latency_valid", bus.o_valid, 1);
                check("latency_data", bus.o_data, acc_d_prev);
            end else if (ov_prev && !or_prev) begin
                check("hold_valid", bus.o_valid, 1);
                check("hold_data", bus.o_data, od_prev);
            end else begin
                check("drain_valid", bus.o_valid, 0);
            end
        end
        check("ready_exclusive", bus.a_ready & bus.b_ready, 0);
        if (bus.o_valid && !bus.o_ready) check("ready_backpressure", bus.a_ready | bus.b_ready, 0);
        if (bus.a_ready) check("sel_a", bus.sel, 0);
        if (bus.b_ready) check("sel_b", bus.sel, 1);

        if (bus.o_valid && bus.o_ready) begin
            log_q.push_back(bus.o_data);
            check("beat_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) check("order", bus.o_data, exp_q.pop_front());
        end

        a_acc      = bus.a_valid && bus.a_ready;
        b_acc      = bus.b_valid && bus.b_ready;
        acc_prev   = a_acc || b_acc;
        acc_d_prev = a_acc ? bus.a_data : bus.b_data;
        if (acc_prev) exp_q.push_back(acc_d_prev);
        if (a_acc) begin
            a_acc_n++;
            if (auto_en && a_up) begin void'(a_src_q.pop_front()); a_up = 1'b0; end
        end
        if (b_acc) begin
            b_acc_n++;
            if (auto_en && b_up) begin void'(b_src_q.pop_front()); b_up = 1'b0; end
        end

        // A waiting requester may see at most one full burst of the other side.
        if (a_acc && bus.b_valid) begin
            a_while_b++;
            check("b_wait_bound", 32'(a_while_b <= (FIXED ? 1 << 30 : MAX_BURST)), 1);
        end
        if (b_acc || !bus.b_valid) a_while_b = 0;
        if (b_acc && bus.a_valid) begin
            b_while_a++;
            check("a_wait_bound", 32'(b_while_a <= MAX_BURST), 1);
        end
        if (a_acc || !bus.a_valid) b_while_a = 0;

        ov_prev = bus.o_valid;
        or_prev = bus.o_ready;
        od_prev = bus.o_data;
        mon_ok  = 1'b1;
    endtask

    task automatic tick_auto();
        @(negedge clk);
        drive_auto();
        #1;
        monitor();
    endtask

    task automatic do_reset(input int cycles);
        auto_en = 1'b0; rand_mode = 1'b0; a_en = 1'b1; b_en = 1'b1;
        a_up = 1'b0; b_up = 1'b0; a_acc_n = 0; b_acc_n = 0;
        a_src_q.delete(); b_src_q.delete(); log_q.delete();
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            rst = 1'b1;
            bus.a_valid = 1'b0; bus.a_data = 8'h00;
            bus.b_valid = 1'b0; bus.b_data = 8'h00;
            bus.o_ready = 1'b1;
            #1;
            monitor();
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        monitor();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t       vecs [NV];
        logic [7:0] want;
        int         n;

        bus.a_valid = 1'b0; bus.a_data = 8'h00;
        bus.b_valid = 1'b0; bus.b_data = 8'h00;
        bus.o_ready = 1'b1;

        // Cycle table, starting from reset: A streams 10..17 (re-grant gap after 4 beats),
        // then a burst stalled 5 cycles by o_ready, then a re-entry that switches to B.
        vecs[0]  = v(1, 8'h10, 0, 8'h00, 1,  0, 0, 0, 0, 8'h00);
        vecs[1]  = v(1, 8'h10, 0, 8'h00, 1,  1, 0, 0, 0, 8'h00);
        vecs[2]  = v(1, 8'h11, 0, 8'h00, 1,  1, 0, 0, 1, 8'h10);
        vecs[3]  = v(1, 8'h12, 0, 8'h00, 1,  1, 0, 0, 1, 8'h11);
        vecs[4]  = v(1, 8'h13, 0, 8'h00, 1,  1, 0, 0, 1, 8'h12);
        vecs[5]  = v(1, 8'h14, 0, 8'h00, 1,  0, 0, 0, 1, 8'h13);
        vecs[6]  = v(1, 8'h14, 0, 8'h00, 1,  1, 0, 0, 0, 8'h13);
        vecs[7]  = v(1, 8'h15, 0, 8'h00, 1,  1, 0, 0, 1, 8'h14);
        vecs[8]  = v(1, 8'h16, 0, 8'h00, 1,  1, 0, 0, 1, 8'h15);
        vecs[9]  = v(1, 8'h17, 0, 8'h00, 1,  1, 0, 0, 1, 8'h16);
        vecs[10] = v(0, 8'h00, 0, 8'h00, 1,  0, 0, 0, 1, 8'h17);
        vecs[11] = v(0, 8'h00, 0, 8'h00, 1,  0, 0, 0, 0, 8'h17);
        vecs[12] = v(1, 8'h20, 0, 8'h00, 1,  0, 0, 0, 0, 8'h17);
        vecs[13] = v(1, 8'h20, 0, 8'h00, 1,  1, 0, 0, 0, 8'h17);
        vecs[14] = v(1, 8'h21, 0, 8'h00, 1,  1, 0, 0, 1, 8'h20);
        vecs[15] = v(1, 8'h22, 0, 8'h00, 0,  0, 0, 0, 1, 8'h21);
        vecs[16] = v(1, 8'h22, 0, 8'h00, 0,  0, 0, 0, 1, 8'h21);
        vecs[17] = v(1, 8'h22, 0, 8'h00, 0,  0, 0, 0, 1, 8'h21);
        vecs[18] = v(1, 8'h22, 0, 8'h00, 0,  0, 0, 0, 1, 8'h21);
        vecs[19] = v(1, 8'h22, 0, 8'h00, 0,  0, 0, 0, 1, 8'h21);
        vecs[20] = v(1, 8'h22, 0, 8'h00, 1,  1, 0, 0, 1, 8'h21);
        vecs[21] = v(1, 8'h23, 0, 8'h00, 1,  1, 0, 0, 1, 8'h22);
        vecs[22] = v(0, 8'h00, 1, 8'hB0, 1,  0, 0, 0, 1, 8'h23);
        vecs[23] = v(0, 8'h00, 1, 8'hB0, 1,  0, 1, 1, 0, 8'h23);
        vecs[24] = v(0, 8'h00, 0, 8'h00, 1,  0, 1, 1, 1, 8'hB0);
        vecs[25] = v(0, 8'h00, 0, 8'h00, 1,  0, 0, 0, 0, 8'hB0);

        // Reset held two cycles with both requesters valid; A must win the first tie.
        a_en = 1'b1; b_en = 1'b1; auto_en = 1'b0; rand_mode = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            rst = 1'b1;
            bus.a_valid = 1'b1; bus.a_data = 8'h55;
            bus.b_valid = 1'b1; bus.b_data = 8'h66;
            bus.o_ready = 1'b1;
            #1;
            if (i == 1) begin
                check("rst_o_valid", bus.o_valid, 0);
                check("rst_o_data", bus.o_data, 0);
                check("rst_a_ready", bus.a_ready, 0);
                check("rst_b_ready", bus.b_ready, 0);
                check("rst_sel", bus.sel, 0);
            end
            monitor();
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_c1_a_ready", bus.a_ready, 0);
        check("post_rst_c1_b_ready", bus.b_ready, 0);
        monitor();
        @(negedge clk);
        #1;
        check("post_rst_c2_a_ready", bus.a_ready, 1);
        check("post_rst_c2_b_ready", bus.b_ready, 0);
        check("post_rst_c2_sel", bus.sel, 0);
        monitor();

        do_reset(1);
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            bus.a_valid = vecs[i].av; bus.a_data = vecs[i].ad;
            bus.b_valid = vecs[i].bv; bus.b_data = vecs[i].bd;
            bus.o_ready = vecs[i].ordy;
            #1;
            check($sformatf("vec%0d_a_ready", i), bus.a_ready, vecs[i].ea);
            check($sformatf("vec%0d_b_ready", i), bus.b_ready, vecs[i].eb);
            check($sformatf("vec%0d_sel", i), bus.sel, vecs[i].es);
            check($sformatf("vec%0d_o_valid", i), bus.o_valid, vecs[i].eov);
            check($sformatf("vec%0d_o_data", i), bus.o_data, vecs[i].eod);
            monitor();
        end

        // Contention: both continuously valid.
        do_reset(1);
        for (int i = 0; i < 8; i++) begin
            a_src_q.push_back(8'hA0 + 8'(i));
            b_src_q.push_back(8'hB0 + 8'(i));
        end
        auto_en = 1'b1;
        n = 0;
        while (log_q.size() < 12 && n < 100) begin tick_auto(); n++; end
        check("contention_timeout", 32'(n < 100), 1);
        for (int i = 0; i < 12 && i < log_q.size(); i++) begin
            if (FIXED) want = (i < 8) ? 8'hA0 + 8'(i) : 8'hB0 + 8'(i - 8);
            else       want = (i < 4) ? 8'hA0 + 8'(i) : (i < 8) ? 8'hB0 + 8'(i - 4) : 8'hA0 + 8'(i - 4);
            check($sformatf("contention_beat%0d", i), log_q[i], want);
        end

        // Early withdraw: A stops after two beats while B waits.
        do_reset(1);
        for (int i = 0; i < 4; i++) begin
            a_src_q.push_back(8'hC0 + 8'(i));
            b_src_q.push_back(8'hD0 + 8'(i));
        end
        auto_en = 1'b1;
        n = 0;
        while (log_q.size() < 6 && n < 100) begin
            tick_auto();
            if (a_acc_n >= 2) a_en = 1'b0;
            n++;
        end
        check("withdraw_timeout", 32'(n < 100), 1);
        for (int i = 0; i < 6 && i < log_q.size(); i++) begin
            want = (i < 2) ? 8'hC0 + 8'(i) : 8'hD0 + 8'(i - 2);
            check($sformatf("withdraw_beat%0d", i), log_q[i], want);
        end
        for (int i = 0; i < 10; i++) tick_auto();
        check("withdraw_no_extra", log_q.size(), 6);

        // Reset while a beat sits in the output stage: it must be discarded.
        do_reset(1);
        for (int i = 0; i < 8; i++) a_src_q.push_back(8'hE0 + 8'(i));
        auto_en = 1'b1;
        n = 0;
        while (a_acc_n < 2 && n < 50) begin tick_auto(); n++; end
        check("midrst_timeout", 32'(n < 50), 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_pre_o_valid", bus.o_valid, 1);
        monitor();
        @(negedge clk);
        rst = 1'b0;
        auto_en = 1'b0;
        bus.a_valid = 1'b0;
        #1;
        check("midrst_o_valid", bus.o_valid, 0);
        check("midrst_o_data", bus.o_data, 0);
        check("midrst_a_ready", bus.a_ready, 0);
        monitor();
        check("midrst_emitted", log_q.size(), 1);

        // Randomized traffic with random valid gaps and backpressure.
        do_reset(1);
        for (int i = 0; i < 150; i++) begin
            a_src_q.push_back(8'($urandom));
            b_src_q.push_back(8'($urandom));
        end
        rand_mode = 1'b1;
        auto_en   = 1'b1;
        n = 0;
        while ((a_src_q.size() != 0 || b_src_q.size() != 0 || bus.o_valid) && n < 5000) begin
            tick_auto();
            n++;
        end
        check("random_timeout", 32'(n < 5000), 1);
        check("random_left_a", a_src_q.size(), 0);
        check("random_left_b", b_src_q.size(), 0);
        check("random_scoreboard_empty", exp_q.size(), 0);
        check("random_beats_out", log_q.size(), 300);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
